// File: rtl/exec_sequencer.sv
// Execution controller between the picoMIPS decoder and datapath: gates commit strobes,
// stalls on MULL via a start/done handshake, counts retired instructions, flags multiplier timeout.
// Optional single-step mode: define SEQ_SINGLE_STEP_EN to add the step input.
`ifndef NOP
`define NOP  6'h00
`endif
`ifndef ADD
`define ADD  6'h01
`endif
`ifndef MULL
`define MULL 6'h0C
`endif

module exec_sequencer #(
    parameter int CNT_W       = 16,
    parameter int MUL_TIMEOUT = 15
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             run,
`ifdef SEQ_SINGLE_STEP_EN
    input  logic             step,
`endif
    input  logic [5:0]       opcode,
    input  logic             dec_w,
    input  logic             dec_pc_incr,
    input  logic             dec_pc_relbranch,
    input  logic             mul_done,
    output logic             w,
    output logic             pc_incr,
    output logic             pc_relbranch,
    output logic             mul_start,
    output logic             busy,
    output logic             fault,
    output logic [CNT_W-1:0] instr_count
);

    localparam int TO_W = (MUL_TIMEOUT > 1) ? $clog2(MUL_TIMEOUT) : 1;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(MUL_TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        EXEC     = 2'd1,
        MUL_WAIT = 2'd2,
        FAULT    = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [TO_W-1:0]  to_cnt_q, to_cnt_d;
    logic             commit;
    logic             step_ok;

`ifdef SEQ_SINGLE_STEP_EN
    assign step_ok = step;
`else
    assign step_ok = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            to_cnt_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            to_cnt_q <= to_cnt_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        to_cnt_d     = to_cnt_q;
        cnt_d        = cnt_q;
        commit       = 1'b0;
        w            = 1'b0;
        pc_incr      = 1'b0;
        pc_relbranch = 1'b0;
        mul_start    = 1'b0;
        busy         = 1'b0;
        fault        = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (run) state_d = EXEC;
            end
            EXEC: begin
                busy = 1'b1;
                if (step_ok) begin
                    if (opcode == `MULL) begin
                        mul_start = 1'b1;
                        to_cnt_d  = '0;
                        state_d   = MUL_WAIT;
                    end else begin
                        w            = dec_w;
                        pc_incr      = dec_pc_incr;
                        pc_relbranch = dec_pc_relbranch;
                        commit       = 1'b1;
                        state_d      = run ? EXEC : IDLE;
                    end
                end
            end
            MUL_WAIT: begin
                busy = 1'b1;
                // done takes priority over a timeout landing in the same cycle
                if (mul_done) begin
                    w       = dec_w;
                    pc_incr = 1'b1;
                    commit  = 1'b1;
                    state_d = run ? EXEC : IDLE;
                end else if (to_cnt_q == TO_LAST) begin
                    state_d = FAULT;
                end else begin
                    to_cnt_d = to_cnt_q + TO_W'(1);
                end
            end
            FAULT: begin
                fault = 1'b1;
            end
            default: state_d = IDLE;
        endcase

        if (commit) cnt_d = cnt_q + CNT_W'(1);

        // reset overrides everything, including the combinational strobes
        if (reset) begin
            w            = 1'b0;
            pc_incr      = 1'b0;
            pc_relbranch = 1'b0;
            mul_start    = 1'b0;
            busy         = 1'b0;
            fault        = 1'b0;
        end
    end

    assign instr_count = cnt_q;

endmodule

// File: tb/tb_exec_sequencer.sv
// Directed self-checking bench for exec_sequencer (CNT_W=4 to exercise counter wrap).
`ifndef NOP
`define NOP  6'h00
`endif
`ifndef ADD
`define ADD  6'h01
`endif
`ifndef MULL
`define MULL 6'h0C
`endif

module tb_exec_sequencer;

    localparam int CNT_W       = 4;
    localparam int MUL_TIMEOUT = 15;

    logic             clk = 1'b0;
    logic             reset, run;
`ifdef SEQ_SINGLE_STEP_EN
    logic             step;
`endif
    logic [5:0]       opcode;
    logic             dec_w, dec_pc_incr, dec_pc_relbranch, mul_done;
    logic             w, pc_incr, pc_relbranch, mul_start, busy, fault;
    logic [CNT_W-1:0] instr_count;

    int n_checks = 0;
    int n_err    = 0;

    always #5 clk = ~clk;

    exec_sequencer #(.CNT_W(CNT_W), .MUL_TIMEOUT(MUL_TIMEOUT)) dut (
        .clk              (clk),
        .reset            (reset),
        .run              (run),
`ifdef SEQ_SINGLE_STEP_EN
        .step             (step),
`endif
        .opcode           (opcode),
        .dec_w            (dec_w),
        .dec_pc_incr      (dec_pc_incr),
        .dec_pc_relbranch (dec_pc_relbranch),
        .mul_done         (mul_done),
        .w                (w),
        .pc_incr          (pc_incr),
        .pc_relbranch     (pc_relbranch),
        .mul_start        (mul_start),
        .busy             (busy),
        .fault            (fault),
        .instr_count      (instr_count)
    );

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic ew, input logic epi, input logic epr,
                           input logic ems, input logic eb);
        check_eq({tag, ".w"},            32'(w),            32'(ew));
        check_eq({tag, ".pc_incr"},      32'(pc_incr),      32'(epi));
        check_eq({tag, ".pc_relbranch"}, 32'(pc_relbranch), 32'(epr));
        check_eq({tag, ".mul_start"},    32'(mul_start),    32'(ems));
        check_eq({tag, ".busy"},         32'(busy),         32'(eb));
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    initial begin
        reset = 1'b1; run = 1'b0; opcode = `NOP;
        dec_w = 1'b0; dec_pc_incr = 1'b0; dec_pc_relbranch = 1'b0; mul_done = 1'b0;
`ifdef SEQ_SINGLE_STEP_EN
        step = 1'b0;
`endif
        // reset for two cycles, then idle with run=0 (stray mul_done ignored)
        cyc();
        smp(); chk_out("rst", 0, 0, 0, 0, 0);
        cyc();
        reset = 1'b0; mul_done = 1'b1;
        for (int i = 0; i < 5; i++) begin
            smp(); chk_out("idle", 0, 0, 0, 0, 0);
            check_eq("idle.fault", 32'(fault), 32'd0);
            check_eq("idle.cnt", 32'(instr_count), 32'd0);
            cyc();
        end
        mul_done = 1'b0;

        // four ADDs: commits in cycles 2..5 after run
        opcode = `ADD; dec_w = 1'b1; dec_pc_incr = 1'b1; run = 1'b1;
        smp(); chk_out("add_c1", 0, 0, 0, 0, 0);
        cyc();
        for (int i = 2; i <= 5; i++) begin
            if (i == 5) run = 1'b0;
            smp(); chk_out("add", 1, 1, 0, 0, 1);
            check_eq("add.cnt", 32'(instr_count), 32'(i - 2));
            cyc();
        end
        smp(); chk_out("add_end", 0, 0, 0, 0, 0);
        check_eq("add_end.cnt", 32'(instr_count), 32'd4);

        // MULL with done 3 cycles after start; run dropped on done -> IDLE
        opcode = `MULL; dec_w = 1'b1; dec_pc_incr = 1'b0; dec_pc_relbranch = 1'b1; run = 1'b1;
        cyc();
        smp(); chk_out("mull_iss", 0, 0, 0, 1, 1);
        cyc();
        for (int i = 0; i < 2; i++) begin
            smp(); chk_out("mull_wait", 0, 0, 0, 0, 1);
            cyc();
        end
        mul_done = 1'b1; run = 1'b0;
        smp(); chk_out("mull_done", 1, 1, 0, 0, 1);
        cyc();
        mul_done = 1'b0;
        smp(); chk_out("mull_end", 0, 0, 0, 0, 0);
        check_eq("mull_end.cnt", 32'(instr_count), 32'd5);

        // reset in MUL_WAIT: outputs forced low, back to IDLE, no re-issue
        run = 1'b1;
        cyc(); cyc();
        reset = 1'b1;
        smp(); chk_out("rst_mul", 0, 0, 0, 0, 0);
        cyc();
        reset = 1'b0; run = 1'b0;
        smp(); chk_out("rst_mul_after", 0, 0, 0, 0, 0);
        check_eq("rst_mul.cnt", 32'(instr_count), 32'd0);

        // MULL without done: FAULT after 15 MUL_WAIT cycles, sticky until reset
        run = 1'b1;
        cyc();
        smp(); chk_out("to_iss", 0, 0, 0, 1, 1);
        cyc();
        for (int k = 1; k <= MUL_TIMEOUT; k++) begin
            smp(); chk_out("to_wait", 0, 0, 0, 0, 1);
            check_eq("to_wait.fault", 32'(fault), 32'd0);
            cyc();
        end
        mul_done = 1'b1;
        for (int i = 0; i < 3; i++) begin
            smp(); chk_out("fault", 0, 0, 0, 0, 0);
            check_eq("fault.flag", 32'(fault), 32'd1);
            cyc();
        end
        mul_done = 1'b0; reset = 1'b1;
        cyc();
        reset = 1'b0; run = 1'b0;
        smp();
        check_eq("fault_clr", 32'(fault), 32'd0);
        check_eq("fault_clr.cnt", 32'(instr_count), 32'd0);

        // done on the 15th wait cycle wins over the timeout
        run = 1'b1;
        cyc(); cyc();
        for (int k = 1; k < MUL_TIMEOUT; k++) cyc();
        mul_done = 1'b1; run = 1'b0;
        smp(); chk_out("to_done", 1, 1, 0, 0, 1);
        check_eq("to_done.fault", 32'(fault), 32'd0);
        cyc();
        mul_done = 1'b0;
        smp();
        check_eq("to_done_after.fault", 32'(fault), 32'd0);
        check_eq("to_done_after.busy", 32'(busy), 32'd0);
        check_eq("to_done_after.cnt", 32'(instr_count), 32'd1);

        // 17 ADDs with a 4-bit counter wraps to 1
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        opcode = `ADD; dec_w = 1'b1; dec_pc_incr = 1'b0; dec_pc_relbranch = 1'b1; run = 1'b1;
        cyc();
        for (int i = 1; i <= 17; i++) begin
            if (i == 17) run = 1'b0;
            smp(); chk_out("wrap", 1, 0, 1, 0, 1);
            if (i >= 15) check_eq("wrap.cnt", 32'(instr_count), 32'((i - 1) % 16));
            cyc();
        end
        smp();
        check_eq("wrap_end.cnt", 32'(instr_count), 32'd1);

`ifdef SEQ_SINGLE_STEP_EN
        // three step pulses -> exactly three commits
        begin
            int commits;
            commits = 0;
            reset = 1'b1;
            cyc();
            reset = 1'b0; run = 1'b1; step = 1'b0; opcode = `ADD; dec_w = 1'b1;
            cyc();
            for (int c = 0; c < 9; c++) begin
                step = (c % 3 == 1);
                smp();
                check_eq("step.w", 32'(w), 32'(step));
                if (w) commits++;
                cyc();
            end
            step = 1'b0;
            check_eq("step.commits", 32'(commits), 32'd3);
            check_eq("step.cnt", 32'(instr_count), 32'd3);
        end
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
